// File: rtl/trig_sched_pkg.sv
// trig_sched_pkg: shared types and default sizes for the trigger-event scheduler
package trig_sched_pkg;
  localparam int TS_W_DEF  = 32;
  localparam int LCT_W_DEF = 8;
  localparam int DEPTH_DEF = 16;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sched_state_t;
  typedef struct packed {
    logic [TS_W_DEF-1:0]  ts;
    logic                 l1a;
    logic                 alct_dav;
    logic                 tmb_dav;
    logic [LCT_W_DEF-1:0] lct;
  } sched_entry_t;
endpackage

// File: rtl/sched_fifo.sv
// sched_fifo: show-ahead FIFO of scheduler entries with synchronous flush
module sched_fifo
  import trig_sched_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  sched_entry_t           din,
  output sched_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  sched_entry_t mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  assign count = wr_q - rd_q;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = wr_q == rd_q;
  assign head  = mem_q[rd_q[AW-1:0]];
  // pointers carry one wrap bit so full and empty are distinguishable; flush also drops a same-cycle push
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push && !full) wr_q <= wr_q + (AW+1)'(1);
      if (pop && !empty) rd_q <= rd_q + (AW+1)'(1);
    end
  end
  // storage is not reset; only slots between the pointers are ever presented
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/trig_event_sched.sv
// trig_event_sched: replays preloaded timestamped trigger entries as single-cycle pulses
module trig_event_sched
  import trig_sched_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TS_W  = TS_W_DEF,
  parameter int LCT_W = LCT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   wr_en,
  input  logic [TS_W-1:0]        wr_ts,
  input  logic                   wr_l1a,
  input  logic                   wr_alct_dav,
  input  logic                   wr_tmb_dav,
  input  logic [LCT_W-1:0]       wr_lct,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   done,
  output logic                   late_err,
  output logic                   ovf_err,
  output logic [TS_W-1:0]        ts_cnt,
  output logic                   l1a,
  output logic                   alct_dav,
  output logic                   tmb_dav,
  output logic [LCT_W-1:0]       lct
);
  sched_state_t state_q;
  sched_entry_t din, head;
  logic [TS_W-1:0] ts_cnt_q;
  logic [LCT_W-1:0] lct_q;
  logic wrap_q, l1a_q, alct_q, tmb_q, done_q, late_q, ovf_q;
  logic run, flush, late, pop, fire;
  assign din   = '{ts: wr_ts, l1a: wr_l1a, alct_dav: wr_alct_dav, tmb_dav: wr_tmb_dav, lct: wr_lct};
  assign run   = state_q == S_RUN;
  assign flush = run && abort;
  // once the counter has wrapped, every remaining entry is overdue
  assign late  = wrap_q || head.ts < ts_cnt_q;
  assign pop   = run && !abort && en && !empty && (late || head.ts == ts_cnt_q);
  assign fire  = pop && !late;
  sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  // sequencer: run state, timestamp counter and the registered one-cycle pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ts_cnt_q <= '0;
      wrap_q   <= 1'b0;
      l1a_q    <= 1'b0;
      alct_q   <= 1'b0;
      tmb_q    <= 1'b0;
      lct_q    <= '0;
      late_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      l1a_q  <= fire && head.l1a;
      alct_q <= fire && head.alct_dav;
      tmb_q  <= fire && head.tmb_dav;
      lct_q  <= fire ? head.lct : '0;
      late_q <= pop && late;
      done_q <= 1'b0;
      ovf_q  <= ovf_q || (wr_en && full);
      if (state_q == S_IDLE) begin
        if (start) begin
          state_q  <= S_RUN;
          ts_cnt_q <= '0;
          wrap_q   <= 1'b0;
        end
      end else if (run) begin
        if (abort) state_q <= S_IDLE;
        else if (empty && !wr_en) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end else if (en) begin
          ts_cnt_q <= ts_cnt_q + TS_W'(1);
          wrap_q   <= wrap_q || &ts_cnt_q;
        end
      end else state_q <= S_IDLE;
    end
  end
  assign busy     = run;
  assign done     = done_q;
  assign late_err = late_q;
  assign ovf_err  = ovf_q;
  assign ts_cnt   = ts_cnt_q;
  assign l1a      = l1a_q;
  assign alct_dav = alct_q;
  assign tmb_dav  = tmb_q;
  assign lct      = lct_q;
endmodule

// File: tb/tb_trig_event_sched.sv
// tb_trig_event_sched: queue-based schedule model checked every cycle plus directed literal checks
module tb_trig_event_sched;
  localparam int DEPTH = 16;
  logic clk = 0, rst = 1, en = 1, start = 0, abort = 0, wr_en = 0;
  logic [31:0] wr_ts = 0;
  logic wr_l1a = 0, wr_alct_dav = 0, wr_tmb_dav = 0;
  logic [7:0] wr_lct = 0;
  logic full, empty, busy, done, late_err, ovf_err, l1a, alct_dav, tmb_dav;
  logic [4:0] count;
  logic [31:0] ts_cnt;
  logic [7:0] lct;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  trig_event_sched dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .abort(abort), .wr_en(wr_en),
    .wr_ts(wr_ts), .wr_l1a(wr_l1a), .wr_alct_dav(wr_alct_dav), .wr_tmb_dav(wr_tmb_dav),
    .wr_lct(wr_lct), .full(full), .empty(empty), .count(count), .busy(busy), .done(done),
    .late_err(late_err), .ovf_err(ovf_err), .ts_cnt(ts_cnt), .l1a(l1a), .alct_dav(alct_dav),
    .tmb_dav(tmb_dav), .lct(lct)
  );
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  // model: pending events in a queue, a run flag and a timestamp; outputs are what the rules say fires
  typedef struct packed {logic [31:0] ts; logic l1a, alct, tmb; logic [7:0] lct;} ev_t;
  ev_t mq[$];
  ev_t mh;
  int mstate = 0;
  logic [31:0] mts = 0;
  bit mwrap = 0, mfull, mflushed, chk_on = 0;
  bit e_l1a, e_alct, e_tmb, e_late, e_done, e_ovf;
  logic [7:0] e_lct;
  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); mstate = 0; mts = 0; mwrap = 0; chk_on = 1;
      {e_l1a, e_alct, e_tmb, e_late, e_done, e_ovf} = '0; e_lct = 0;
    end else begin
      mfull = mq.size() == DEPTH;
      mflushed = 0;
      {e_l1a, e_alct, e_tmb, e_late, e_done} = '0; e_lct = 0;
      if (wr_en && mfull) e_ovf = 1;
      if (mstate == 1) begin
        if (abort) begin mq.delete(); mstate = 0; mflushed = 1; end
        else if (mq.size() == 0 && !wr_en) begin mstate = 2; e_done = 1; end
        else if (en) begin
          if (mq.size() != 0 && (mwrap || mq[0].ts <= mts)) begin
            mh = mq.pop_front();
            if (!mwrap && mh.ts == mts) begin
              e_l1a = mh.l1a; e_alct = mh.alct; e_tmb = mh.tmb; e_lct = mh.lct;
            end else e_late = 1;
          end
          if (mts == 32'hFFFF_FFFF) mwrap = 1;
          mts = mts + 1;
        end
      end else if (mstate == 2) mstate = 0;
      else if (start) begin mstate = 1; mts = 0; mwrap = 0; end
      if (wr_en && !mfull && !mflushed) mq.push_back('{wr_ts, wr_l1a, wr_alct_dav, wr_tmb_dav, wr_lct});
    end
  end
  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      check("l1a", l1a, e_l1a);
      check("alct_dav", alct_dav, e_alct);
      check("tmb_dav", tmb_dav, e_tmb);
      check("lct", lct, e_lct);
      check("late_err", late_err, e_late);
      check("done", done, e_done);
      check("ovf_err", ovf_err, e_ovf);
      check("busy", busy, mstate == 1);
      check("ts_cnt", ts_cnt, mts);
      check("count", count, mq.size());
      check("full", full, mq.size() == DEPTH);
      check("empty", empty, mq.size() == 0);
    end
  end
  int pulses[$], lates[$], dones[$];
  int idle_cyc;
  function automatic int pk(int c, logic a, logic b, logic t, logic [7:0] p);
    return c * 4096 + int'({a, b, t}) * 256 + int'(p);
  endfunction
  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
  endtask
  task automatic wr(input logic [31:0] ts, input logic a, input logic b, input logic t, input logic [7:0] p);
    @(negedge clk);
    wr_en = 1; wr_ts = ts; wr_l1a = a; wr_alct_dav = b; wr_tmb_dav = t; wr_lct = p;
    @(negedge clk); wr_en = 0;
  endtask
  // start a run and log pulse cycles relative to the edge that sampled start
  task automatic run(input int max, input int en_lo, input int en_hi, input int ab_at);
    pulses.delete(); lates.delete(); dones.delete(); idle_cyc = -1;
    @(negedge clk); start = 1;
    for (int c = 1; c <= max; c++) begin
      @(negedge clk); start = 0; abort = 0;
      if (l1a || alct_dav || tmb_dav || lct != 0) pulses.push_back(pk(c, l1a, alct_dav, tmb_dav, lct));
      if (late_err) lates.push_back(c);
      if (done) dones.push_back(c);
      if (!busy) begin idle_cyc = c; break; end
      en = !(c >= en_lo && c <= en_hi);
      abort = (c == ab_at);
    end
    en = 1; abort = 0;
    check("run_within_bound", idle_cyc > 0, 1);
  endtask
  initial begin
    @(negedge clk); @(negedge clk); rst = 0;
    check("rst_empty", empty, 1);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    // two events at ts 3 and 5
    wr(3, 1, 0, 0, 8'h01);
    wr(5, 0, 0, 1, 8'h80);
    check("t1_count", count, 2);
    run(40, 0, -1, 0);
    check("t1_npulse", pulses.size(), 2);
    check("t1_p0", pulses[0], pk(5, 1, 0, 0, 8'h01));
    check("t1_p1", pulses[1], pk(7, 0, 0, 1, 8'h80));
    check("t1_done", dones.size() == 1 && dones[0] == 8, 1);
    check("t1_idle", idle_cyc, 8);
    // adjacent timestamps give adjacent pulses
    wr(4, 1, 0, 0, 8'h04);
    wr(5, 0, 1, 0, 8'h05);
    run(40, 0, -1, 0);
    check("t2_npulse", pulses.size(), 2);
    check("t2_p0", pulses[0], pk(6, 1, 0, 0, 8'h04));
    check("t2_p1", pulses[1], pk(7, 0, 1, 0, 8'h05));
    // duplicate timestamp: second is late
    wr(6, 1, 0, 0, 8'h06);
    wr(6, 0, 0, 1, 8'h66);
    run(40, 0, -1, 0);
    check("t3_npulse", pulses.size(), 1);
    check("t3_p0", pulses[0], pk(8, 1, 0, 0, 8'h06));
    check("t3_late", lates.size() == 1 && lates[0] == 9, 1);
    check("t3_done", dones.size() == 1 && dones[0] == 10, 1);
    // enable low for 3 cycles delays the pulse by 3
    wr(10, 1, 0, 0, 8'h0A);
    run(40, 3, 5, 0);
    check("t4_npulse", pulses.size(), 1);
    check("t4_p0", pulses[0], pk(15, 1, 0, 0, 8'h0A));
    check("t4_ts_final", ts_cnt, 11);
    // overflow: DEPTH+1 writes, only DEPTH replay
    for (int i = 0; i <= DEPTH; i++) wr(32'(20 + i), 1, 0, 0, 8'(i));
    check("t5_full", full, 1);
    check("t5_count", count, DEPTH);
    check("t5_ovf", ovf_err, 1);
    run(60, 0, -1, 0);
    check("t5_npulse", pulses.size(), DEPTH);
    check("t5_first", pulses[0], pk(22, 1, 0, 0, 8'h00));
    check("t5_last", pulses[DEPTH-1], pk(37, 1, 0, 0, 8'h0F));
    check("t5_done", dones.size() == 1 && dones[0] == 38, 1);
    // abort at ts_cnt=2 with four pending
    do_reset();
    check("t6_ovf_cleared", ovf_err, 0);
    for (int i = 0; i < 4; i++) wr(32'(5 + i), 1, 0, 0, 8'(i + 1));
    run(20, 0, -1, 3);
    check("t6_idle", idle_cyc, 4);
    check("t6_empty", empty, 1);
    check("t6_nopulse", pulses.size(), 0);
    check("t6_nodone", dones.size(), 0);
    repeat (3) @(negedge clk);
    // reset in the middle of a pulse
    wr(2, 1, 0, 0, 8'h02);
    @(negedge clk); start = 1;
    for (int c = 1; c <= 20 && !l1a; c++) begin @(negedge clk); start = 0; end
    check("t7_pulse_seen", l1a, 1);
    rst = 1;
    @(negedge clk); rst = 0;
    check("t7_l1a", l1a, 0);
    check("t7_lct", lct, 0);
    check("t7_busy", busy, 0);
    check("t7_ts", ts_cnt, 0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/trig_event_sched.md
# trig_event_sched

Synthesizable timestamped trigger-event scheduler that drives the ODMB trigger inputs (`l1a`, `alct_dav`, `tmb_dav`, `lct[7:0]`) from a preloaded list of events. Software or a bench loads timestamped entries into an internal FIFO. After `start`, a free-running timestamp counter replays each entry as a one-cycle pulse on the exact cycle it is due. The block sits in front of the trigger/DAV datapath and can be used in-system for pattern injection or in simulation in place of file-driven stimulus.

## Interface
- `DEPTH`, 16: entry FIFO depth; must be a power of 2, ≥ 2.
- `TS_W`, 32: timestamp and counter width.
- `LCT_W`, 8: LCT bit-vector width.

- `clk`  in  1  system clock; only clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  counter/match enable; low freezes the schedule.
- `start`  in  1  IDLE→RUN; clears the counter.
- `abort`  in  1  RUN→IDLE; flushes the FIFO.
- `wr_en`  in  1  write one entry.
- `wr_ts`  in  TS_W  entry timestamp.
- `wr_l1a`, `wr_alct_dav`, `wr_tmb_dav`  in  1 each  entry flags.
- `wr_lct`  in  LCT_W  entry LCT pattern.
- `full`, `empty`  out  1  FIFO status.
- `count`  out  log2(DEPTH)+1  entries held.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when a run drains.
- `late_err`  out  1  one-cycle pulse when a late entry is discarded.
- `ovf_err`  out  1  sticky; a write was dropped because the FIFO was full.
- `ts_cnt`  out  TS_W  current timestamp.
- `l1a`, `alct_dav`, `tmb_dav`  out  1  scheduled pulses.
- `lct`  out  LCT_W  scheduled LCT pattern.

## Operation
- Reset values:
  - All outputs are 0; `empty`=1; state is IDLE.
  - FIFO pointers are cleared; `ovf_err` is cleared (reset is its only clear).
- Writes:
  - A write is accepted when `wr_en` is high and `full` is low, in any state.
  - A write with `full` high is dropped and sets `ovf_err`. A pop in the same cycle does not rescue it.
- States: IDLE, RUN, DONE.
  - IDLE: `start` clears `ts_cnt` to 0 and moves to RUN. Outputs stay 0.
  - RUN, `en`=1: compares the FIFO head against `ts_cnt`, then increments `ts_cnt`.
    - `head.ts == ts_cnt`: pop the head; drive its flags and `lct` on the next cycle.
    - `head.ts < ts_cnt` (unsigned): pop the head; pulse `late_err` on the next cycle; trigger outputs stay 0.
    - `head.ts > ts_cnt`: no action.
    - At most one pop per cycle.
  - RUN, `en`=0: `ts_cnt` holds; no compare and no pop.
  - RUN with FIFO empty and no pending write moves to DONE.
  - DONE: pulse `done` for 1 cycle, then return to IDLE.
  - `abort` in RUN flushes the FIFO (`empty`=1 next cycle), zeroes the outputs and returns to IDLE. No `done` pulse.
- Event rules:
  - Entries must be written in non-decreasing timestamp order.
  - A second entry with the same timestamp as the previous one is late by construction, so it is discarded with `late_err`.
- Counter wrap: `ts_cnt` wraps from all-ones to 0 and keeps running. Entries due after the wrap are treated as late.
- `start` in RUN or DONE is ignored. `abort` in IDLE is ignored.
- Precedence: `rst` over `abort` over `start`.

## Timing
- Compare at cycle k with `ts_cnt`=N; the matching outputs are high in cycle k+1 only. Fixed latency of 1 cycle.
- The first compare after `start` (asserted at cycle s) occurs in cycle s+1 with `ts_cnt`=0.
- All outputs are registered. The pulse width is always exactly 1 cycle; back-to-back timestamps give back-to-back pulses.
- `count` and `full`/`empty` update the cycle after a write or pop.
- A mid-run `rst` clears everything the next cycle, including an in-flight pulse.

## Structure
- Package `trig_sched_pkg`:
  - `sched_entry_t` struct: `ts`, `l1a`, `alct_dav`, `tmb_dav`, `lct`.
  - State enum.
  - Default `TS_W`, `LCT_W`, `DEPTH` constants.
- Sub-module `sched_fifo`: synchronous show-ahead FIFO of `sched_entry_t` with `push`, `pop`, `flush`, `count`, `full` and `empty`.
- The top level holds the FSM, the counter, the comparator and the output registers.

## Test plan
- Load (ts=3, l1a=1, lct=0x01) and (ts=5, tmb_dav=1, lct=0x80); `start`, `en`=1 → `l1a` high in the cycle after `ts_cnt`=3 and `tmb_dav`/`lct`=0x80 one cycle after `ts_cnt`=5; then `done` pulses once and `busy` falls.
- Entries at ts=4 and ts=5 → two consecutive one-cycle pulses with no gap.
- Entries at ts=6 and ts=6 → first fires; second gives `late_err`=1 with all trigger outputs 0.
- Drop `en` for 3 cycles before ts=10 → `ts_cnt` holds; the pulse is delayed by exactly 3 cycles.
- Write DEPTH+1 entries in IDLE → `full`=1, `count`=DEPTH, `ovf_err`=1; only DEPTH entries replay.
- `abort` at `ts_cnt`=2 with 4 entries pending → `empty`=1 next cycle, no pulses, no `done`. A `rst` mid-pulse → outputs 0 next cycle.
